// File: rtl/imem_arbiter.sv
// imem_arbiter: serialises two cache-refill block reads onto one memory port with a ren gap between transactions.
// Build option IMEM_ARB_FIXED_PRIO_EN: requester 0 always wins ties (no last_grant, requester 1 may starve).
module imem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_dout
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] RESP  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    logic [2:0] state;
    logic       gnt;
    logic       pick;

`ifdef IMEM_ARB_FIXED_PRIO_EN
    // Requester 0 takes every tie; requester 1 only wins when alone.
    always_comb pick = !req0;
`else
    logic last_grant;

    // On a tie pick the port that was not served last, otherwise whoever is asking.
    always_comb pick = (req0 && req1) ? !last_grant : !req0;

    // Remember the most recent grant; reset favours requester 0 on the first tie.
    always_ff @(posedge clock or negedge reset)
        if (!reset) last_grant <= 1'b1;
        else if (state == IDLE && (req0 || req1)) last_grant <= pick;
`endif

    // Transaction sequencer: grant, issue, wait for ready, acknowledge, then force a ren-low gap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= '0;
            mem_ren  <= 1'b0;
            mem_addr <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    gnt      <= pick;
                    mem_addr <= pick ? addr1 : addr0;
                    mem_ren  <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: if (mem_ready) begin
                    rdata   <= mem_dout;
                    mem_ren <= 1'b0;
                    ack0    <= !gnt;
                    ack1    <= gnt;
                    state   <= RESP;
                end
                RESP: state <= GAP;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = state != IDLE;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios plus random traffic against a cycle-arithmetic transaction model.
`timescale 1ns/1ps
module tb_imem_arbiter;
    localparam int AW = 10;
    localparam int DW = 128;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          ack0, ack1, busy, mem_ren;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] rdata, mem_dout;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .addr0(addr0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .ack1(ack1),
        .rdata(rdata), .busy(busy),
        .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_dout(mem_dout)
    );

    function automatic logic [DW-1:0] blk(logic [AW-1:0] a);
        return {32'hDEADBEEF, 16'hCAFE, 6'd0, a, ~{22'd0, a}, 22'd0, a};
    endfunction

    task automatic chk(string n, logic [DW-1:0] a, logic [DW-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Memory: ready rises mem_d cycles after ren rises, drops when ren drops; data valid only with ready && ren.
    int mem_d = 4;
    int mem_cnt = 0;
    always @(posedge clock) begin
        if (!mem_ren) begin
            mem_cnt   <= 0;
            mem_ready <= 1'b0;
        end else begin
            mem_cnt   <= mem_cnt + 1;
            mem_ready <= (mem_cnt + 1 >= mem_d);
        end
    end
    assign mem_dout = (mem_ready && mem_ren) ? blk(mem_addr) : ~blk(mem_addr);

    // Transaction model: a grant in idle cycle t with memory delay d acks in cycle t+max(3,d+2),
    // ren is high from t+1 up to the ack cycle, busy until the cycle after the ack.
    int            cyc = 0;
    bit            m_act = 0;
    int            m_t = 0, m_a = 0;
    bit            m_g = 0, m_last = 1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            rnd_delay = 0;

    always @(posedge clock) begin
        if (!reset) begin
            m_act   = 0;
            m_last  = 1;
            m_rdata = '0;
            m_addr  = '0;
        end else if (m_act && cyc == m_a + 1) begin
            m_act = 0;
        end else if (!m_act && (req0 || req1)) begin
            int d;
`ifdef IMEM_ARB_FIXED_PRIO_EN
            m_g = !req0;
`else
            m_g = (req0 && req1) ? (m_last == 0) : req1;
`endif
            m_last = m_g;
            m_addr = m_g ? addr1 : addr0;
            d = rnd_delay ? int'($urandom_range(1, 6)) : 4;
            mem_d = d;
            m_t = cyc;
            m_a = cyc + ((d + 2 > 3) ? d + 2 : 3);
            m_act = 1;
        end
        cyc = cyc + 1;
        if (m_act && cyc == m_a) m_rdata = blk(m_addr);
    end

    // Compare every output against the model mid-cycle whenever reset is released.
    always @(negedge clock) begin
        if (reset) begin
            chk("mem_ren", DW'(mem_ren), DW'(m_act && cyc > m_t && cyc < m_a));
            chk("mem_addr", DW'(mem_addr), DW'(m_addr));
            chk("ack0", DW'(ack0), DW'(m_act && cyc == m_a && !m_g));
            chk("ack1", DW'(ack1), DW'(m_act && cyc == m_a && m_g));
            chk("busy", DW'(busy), DW'(m_act && cyc > m_t));
            chk("rdata", rdata, m_rdata);
        end
    end

    bit acks[$];
    int ack_cyc[$];
    int first_cyc;

    // Keep enabled ports requesting until n acks arrive; again=1 re-requests after each ack.
    task automatic run(int n, bit en0, bit en1, bit again);
        int seen = 0;
        int budget = 0;
        bit done0 = 0, done1 = 0;
        acks.delete();
        ack_cyc.delete();
        while (seen < n && budget < 200) begin
            @(negedge clock);
            budget++;
            if (budget == 1) first_cyc = cyc;
            if (ack0) begin
                acks.push_back(1'b0); ack_cyc.push_back(cyc); seen++; req0 = 0; done0 = 1;
            end else if (en0 && (again || !done0)) req0 = 1;
            if (ack1) begin
                acks.push_back(1'b1); ack_cyc.push_back(cyc); seen++; req1 = 0; done1 = 1;
            end else if (en1 && (again || !done1)) req1 = 1;
        end
        chk("ack_count", DW'(seen), DW'(n));
        req0 = 0;
        req1 = 0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 0;
        repeat (2) @(negedge clock);
        reset = 1;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_ren", DW'(mem_ren), '0);
        chk("rst_ack0", DW'(ack0), '0);
        chk("rst_ack1", DW'(ack1), '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_addr", DW'(mem_addr), '0);
        reset = 1;
        settle();

        addr0 = 10'h012;
        run(1, 1, 0, 0);
        chk("single_port", DW'(acks[0]), '0);
        chk("single_lat", DW'(ack_cyc[0] - first_cyc), DW'(6));
        chk("single_data", rdata, {32'hDEADBEEF, 32'hCAFE0012, 32'hFFFFFFED, 32'h00000012});
        settle();
        chk("single_idle", DW'(busy), '0);

        do_reset();
        addr0 = 10'h001;
        addr1 = 10'h002;
        run(2, 1, 1, 0);
        chk("tie_first", DW'(acks[0]), '0);
        chk("tie_second", DW'(acks[1]), DW'(1));
        chk("tie_spacing", DW'(ack_cyc[1] - ack_cyc[0]), DW'(8));
        chk("tie_data", rdata, {32'hDEADBEEF, 32'hCAFE0002, 32'hFFFFFFFD, 32'h00000002});
        settle();

        do_reset();
        addr0 = 10'h101;
        addr1 = 10'h202;
        run(4, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
            chk("rr_order", DW'(acks[i]), '0);
`else
            chk("rr_order", DW'(acks[i]), DW'(i % 2));
`endif
        end
        settle();

        addr0 = 10'h030;
        @(negedge clock);
        req0 = 1;
        repeat (3) @(negedge clock);
        addr1 = 10'h031;
        run(2, 1, 1, 0);
        chk("late_first", DW'(acks[0]), '0);
        chk("late_second", DW'(acks[1]), DW'(1));
        chk("late_spacing", DW'(ack_cyc[1] - ack_cyc[0]), DW'(8));
        settle();

        addr0 = 10'h040;
        @(negedge clock);
        req0 = 1;
        repeat (3) @(negedge clock);
        reset = 0;
        #1;
        chk("async_ren", DW'(mem_ren), '0);
        chk("async_ack0", DW'(ack0), '0);
        chk("async_ack1", DW'(ack1), '0);
        chk("async_busy", DW'(busy), '0);
        chk("async_rdata", rdata, '0);
        repeat (2) @(negedge clock);
        reset = 1;
        run(1, 1, 0, 0);
        chk("regrant_port", DW'(acks[0]), '0);
        chk("regrant_data", rdata, blk(10'h040));
        settle();

        addr0 = 10'h010;
        @(negedge clock);
        req0 = 1;
        repeat (3) @(negedge clock);
        addr0 = 10'h020;
        #1;
        chk("hold_addr", DW'(mem_addr), DW'(10'h010));
        run(1, 1, 0, 0);
        chk("hold_data", rdata, {32'hDEADBEEF, 32'hCAFE0010, 32'hFFFFFFEF, 32'h00000010});
        settle();

        rnd_delay = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (ack0) req0 = 0;
            else if (!req0 && $urandom_range(3) == 0) begin req0 = 1; addr0 = AW'($urandom); end
            else if (req0 && m_act && !m_g && $urandom_range(7) == 0) addr0 = AW'($urandom);
            if (ack1) req1 = 0;
            else if (!req1 && $urandom_range(3) == 0) begin req1 = 1; addr1 = AW'($urandom); end
            else if (req1 && m_act && m_g && $urandom_range(7) == 0) addr1 = AW'($urandom);
        end
        req0 = 0;
        req1 = 0;
        repeat (12) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
